// File: rtl/priority_encoder_pkg.sv
// Shared definitions for the priority encoder: default width, index-width
// helper and the packed result record carried through the output register.
package priority_encoder_pkg;

  localparam int PRIO_N_DEFAULT = 16;
  localparam int PRIO_N_MAX     = 256;
  localparam int PRIO_W_MAX     = 8;

  function automatic int prio_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Sized for the largest legal N; instances use the low N / W bits only.
  typedef struct packed {
    logic [PRIO_W_MAX-1:0] idx;
    logic [PRIO_N_MAX-1:0] onehot;
    logic                  none;
  } prio_result_t;

endpackage

// File: rtl/prio_find_first.sv
// Combinational circular first-set search: scans upward from start_i,
// wrapping N-1 -> 0, and reports the first set bit of vec_i.
module prio_find_first
  import priority_encoder_pkg::*;
#(
  parameter int  N = PRIO_N_DEFAULT,
  localparam int W = prio_idx_w(N)
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o,
  output logic         none_o
);

  int pos;

  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
    none_o   = 1'b1;
    pos      = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start_i) + k;
      if (pos >= N) pos = pos - N;
      if (none_o && vec_i[pos]) begin
        none_o        = 1'b0;
        idx_o         = pos[W-1:0];
        onehot_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder_rr.sv
// Registered priority encoder with a single-entry valid/ready output stage.
// Define PRIORITY_ENCODER_RR_EN for round-robin priority; otherwise the
// lowest set index wins.
module priority_encoder_rr
  import priority_encoder_pkg::*;
#(
  parameter int  N = PRIO_N_DEFAULT,
  localparam int W = prio_idx_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic         grant_none,
  output logic         grant_valid,
  input  logic         grant_ready
);

  logic         valid_q, valid_d;
  prio_result_t res_q, res_d;
  logic         accept;
  logic [W-1:0] start;
  logic [W-1:0] f_idx;
  logic [N-1:0] f_onehot;
  logic         f_none;

  assign req_ready = !valid_q || grant_ready;
  assign accept    = req_valid && req_ready;

  prio_find_first #(.N(N)) u_find (
    .vec_i    (req),
    .start_i  (start),
    .idx_o    (f_idx),
    .onehot_o (f_onehot),
    .none_o   (f_none)
  );

`ifdef PRIORITY_ENCODER_RR_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Pointer moves past the winner only on accepted non-empty vectors.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && !f_none) begin
      ptr_d = (f_idx == W'(N - 1)) ? '0 : f_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    if (accept) begin
      valid_d              = 1'b1;
      res_d                = '0;
      res_d.idx[W-1:0]     = f_idx;
      res_d.onehot[N-1:0]  = f_onehot;
      res_d.none           = f_none;
    end else if (grant_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register stage: accepted vector appears here one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  assign grant_valid  = valid_q;
  assign grant_idx    = res_q.idx[W-1:0];
  assign grant_onehot = res_q.onehot[N-1:0];
  assign grant_none   = res_q.none;

  // Bits above N / W must stay clear, and the one-hot must match the index.
  always_ff @(posedge clk) begin
    if (rst_n && valid_q) begin
      assert (int'(res_q.idx) < N);
      assert ((res_q.onehot >> N) == '0);
      assert (res_q.none || (res_q.onehot[N-1:0] == (N'(1) << res_q.idx[W-1:0])));
    end
  end

endmodule
